// File: rtl/int_dot_acc_pipe_if.sv
// Handshake bundle for int_dot_acc_pipe. It carries the operand-beat channel
// (valid/ready, lanes, mode, last) and the result channel (valid/ready, total, overflow).
interface int_dot_acc_pipe_if #(
    parameter int W_IN_A  = 8,
    parameter int W_IN_B  = 5,
    parameter int N_LANES = 4,
    parameter int W_ACC   = 32
);
    // Operand beat channel
    logic                        in_valid;
    logic                        in_ready;
    logic [N_LANES*W_IN_A-1:0]   in_a;
    logic [N_LANES*W_IN_B-1:0]   in_b;
    logic                        in_unsigned;
    logic                        in_last;

    // Result channel
    logic                        out_valid;
    logic                        out_ready;
    logic signed [W_ACC-1:0]     out_x;
    logic                        out_ovf;

    // Producer of beats / consumer of results
    modport master (
        output in_valid, in_a, in_b, in_unsigned, in_last, out_ready,
        input  in_ready, out_valid, out_x, out_ovf
    );

    // The dot-product unit itself
    modport slave (
        input  in_valid, in_a, in_b, in_unsigned, in_last, out_ready,
        output in_ready, out_valid, out_x, out_ovf
    );
endinterface

// File: rtl/int_dot_acc_pipe.sv
// Pipelined N-lane integer dot-product unit with running accumulator.
// S1 registers the per-lane products, S2 registers the adder-tree sum, S3 folds
// the sum into the accumulator and emits the total on the beat marked last.
// A single global enable (no result stall) advances every stage together.
module int_dot_acc_pipe #(
    parameter int W_IN_A  = 8,
    parameter int W_IN_B  = 5,
    parameter int N_LANES = 4,
    parameter int W_ACC   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    int_dot_acc_pipe_if.slave    dp
);

    localparam int W_AE   = W_IN_A + 1;              // extended A operand
    localparam int W_BE   = W_IN_B + 1;              // extended B operand
    localparam int W_P    = W_IN_A + W_IN_B + 1;     // signed product width
    localparam int LVL    = $clog2(N_LANES);         // adder-tree depth
    localparam int N_LEAF = 1 << LVL;                // leaves padded to a power of two
    localparam int W_S    = W_P + LVL;               // tree sum width, cannot overflow

    typedef logic signed [W_P-1:0]   prod_t;
    typedef logic signed [W_S-1:0]   sum_t;
    typedef logic signed [W_ACC-1:0] acc_t;

    // Elaboration-time guards on the parameter set
    if (N_LANES < 1) begin : g_bad_lanes
        $error("int_dot_acc_pipe: N_LANES must be at least 1");
    end
    if (W_ACC < W_S) begin : g_bad_acc
        $error("int_dot_acc_pipe: W_ACC too narrow for one beat sum");
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic   en;

    logic   s1_valid_q, s1_valid_d;
    logic   s1_last_q,  s1_last_d;
    prod_t  s1_prod_q [N_LANES];
    prod_t  s1_prod_d [N_LANES];

    logic   s2_valid_q, s2_valid_d;
    logic   s2_last_q,  s2_last_d;
    acc_t   s2_sum_q,   s2_sum_d;

    acc_t   acc_q,      acc_d;
    logic   ovf_q,      ovf_d;
    acc_t   out_x_q,    out_x_d;
    logic   out_ovf_q,  out_ovf_d;
    logic   out_valid_q, out_valid_d;

    acc_t   acc_sum;
    logic   add_ovf;
    sum_t   tree [2*N_LEAF-1];

    // ------------------------------------------------------------------
    // Flow control: the only stall source is a result nobody takes yet.
    // out_ready -> in_ready is the single combinational path through the block.
    // ------------------------------------------------------------------
    assign en           = !(out_valid_q && !dp.out_ready);
    assign dp.in_ready  = en;
    assign dp.out_valid = out_valid_q;
    assign dp.out_x     = out_x_q;
    assign dp.out_ovf   = out_ovf_q;

    // S1 next state: extend each lane per this beat's mode bit and multiply
    always_comb begin
        logic signed [W_AE-1:0] a_ext;
        logic signed [W_BE-1:0] b_ext;
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path through the block can leave it holding a stale value
        // (which would infer a latch).
        a_ext      = '0;
        b_ext      = '0;
        s1_valid_d = dp.in_valid;
        s1_last_d  = dp.in_last;
        for (int i = 0; i < N_LANES; i++) begin
            a_ext = {~dp.in_unsigned & dp.in_a[i*W_IN_A + W_IN_A - 1],
                     dp.in_a[i*W_IN_A +: W_IN_A]};
            b_ext = {~dp.in_unsigned & dp.in_b[i*W_IN_B + W_IN_B - 1],
                     dp.in_b[i*W_IN_B +: W_IN_B]};
            // The true product always fits in W_P signed bits, so the
            // W_P-wide evaluation loses nothing.
            s1_prod_d[i] = prod_t'(a_ext * b_ext);
        end
    end

    // S2 next state: balanced adder tree over the registered products
    always_comb begin
        for (int k = 0; k < 2*N_LEAF-1; k++) begin
            tree[k] = '0;
        end
        // Leaves live at the tail of the array; unused leaves stay zero
        for (int i = 0; i < N_LANES; i++) begin
            tree[N_LEAF-1+i] = sum_t'(s1_prod_q[i]);
        end
        // Node k sums its two children; tree[0] is the root
        for (int k = N_LEAF-2; k >= 0; k--) begin
            tree[k] = tree[2*k+1] + tree[2*k+2];
        end
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_sum_d   = acc_t'(tree[0]);
    end

    // S3 next state: accumulate, track signed overflow, emit on last
    always_comb begin
        acc_sum = acc_q + s2_sum_q;
        add_ovf = (acc_q[W_ACC-1] == s2_sum_q[W_ACC-1]) &&
                  (acc_sum[W_ACC-1] != acc_q[W_ACC-1]);

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_x_d     = out_x_q;
        out_ovf_d   = out_ovf_q;
        // Only consumed while enabled, i.e. when any held result is being
        // taken this cycle, so the default is to drop out_valid.
        out_valid_d = 1'b0;

        if (s2_valid_q) begin
            if (s2_last_q) begin
                out_x_d     = acc_sum;
                out_ovf_d   = ovf_q | add_ovf;
                out_valid_d = 1'b1;
                acc_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d       = acc_sum;
                ovf_d       = ovf_q | add_ovf;
            end
        end
    end

    // Control and accumulator state: synchronous reset, advance on enable
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with non-blocking (<=) so every
        // register samples its inputs from before the edge, in any order.
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_x_q     <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_x_q     <= out_x_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Datapath payload registers advance on enable
    always_ff @(posedge clk) begin
        // NOTE: payload registers are left without reset; they are only ever
        // consumed under a stage valid that is reset, so clearing them buys nothing.
        if (en) begin
            s1_prod_q <= s1_prod_d;
            s2_sum_q  <= s2_sum_d;
        end
    end

endmodule

// File: tb/tb_int_dot_acc_pipe.sv
// Testbench for int_dot_acc_pipe: two instances (32-bit and 16-bit accumulator)
// share one stimulus stream; a plain-arithmetic model predicts every result.
module tb_int_dot_acc_pipe;

    localparam int WA = 8;
    localparam int WB = 5;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_dot_acc_pipe_if #(.W_IN_A(WA), .W_IN_B(WB), .N_LANES(NL), .W_ACC(32)) bus32 ();
    int_dot_acc_pipe_if #(.W_IN_A(WA), .W_IN_B(WB), .N_LANES(NL), .W_ACC(16)) bus16 ();

    int_dot_acc_pipe #(.W_IN_A(WA), .W_IN_B(WB), .N_LANES(NL), .W_ACC(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .dp  (bus32.slave)
    );
    int_dot_acc_pipe #(.W_IN_A(WA), .W_IN_B(WB), .N_LANES(NL), .W_ACC(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .dp  (bus16.slave)
    );

    // Shared drive
    logic              drv_valid, drv_uns, drv_last, drv_ready;
    logic [NL*WA-1:0]  drv_a;
    logic [NL*WB-1:0]  drv_b;

    assign bus32.in_valid = drv_valid;    assign bus16.in_valid = drv_valid;
    assign bus32.in_a = drv_a;            assign bus16.in_a = drv_a;
    assign bus32.in_b = drv_b;            assign bus16.in_b = drv_b;
    assign bus32.in_unsigned = drv_uns;   assign bus16.in_unsigned = drv_uns;
    assign bus32.in_last = drv_last;      assign bus16.in_last = drv_last;
    assign bus32.out_ready = drv_ready;   assign bus16.out_ready = drv_ready;

    // Reference model state
    typedef struct packed { logic signed [63:0] x; logic ovf; } res_t;
    res_t   exp32[$];
    res_t   exp16[$];
    longint acc32, acc16;
    bit     ovf32, ovf16;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_res = 0;
    int     n_stall = 0;
    int     holdoff = 0;
    bit     rand_ready = 0;
    bit     obs_acc, obs_out, prev_stall;
    longint prev_x32;
    longint last_x32, last_x16;
    bit     last_o32, last_o16;

    task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap(longint v, int w);
        longint m = longint'(1) << w;
        longint r = v & (m - 1);
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Dot product of one beat with ordinary integer arithmetic
    function automatic longint beat_sum(logic [NL*WA-1:0] a, logic [NL*WB-1:0] b, logic uns);
        longint s = 0;
        for (int i = 0; i < NL; i++) begin
            longint av = longint'(a[i*WA +: WA]);
            longint bv = longint'(b[i*WB +: WB]);
            if (!uns) begin
                if (av >= (longint'(1) << (WA-1))) av -= (longint'(1) << WA);
                if (bv >= (longint'(1) << (WB-1))) bv -= (longint'(1) << WB);
            end
            s += av * bv;
        end
        return s;
    endfunction

    function automatic longint add_wrap(longint acc, longint s, int w, output bit o);
        longint t = acc + s;
        longint r = wrap(t, w);
        o = (r != t);
        return r;
    endfunction

    task automatic model_accept();
        longint s = beat_sum(drv_a, drv_b, drv_uns);
        longint r;
        bit     o;
        res_t   e;
        r = add_wrap(acc32, s, 32, o);
        if (drv_last) begin
            e.x = r; e.ovf = ovf32 | o; exp32.push_back(e); acc32 = 0; ovf32 = 0;
        end else begin
            acc32 = r; ovf32 = ovf32 | o;
        end
        r = add_wrap(acc16, s, 16, o);
        if (drv_last) begin
            e.x = r; e.ovf = ovf16 | o; exp16.push_back(e); acc16 = 0; ovf16 = 0;
        end else begin
            acc16 = r; ovf16 = ovf16 | o;
        end
    endtask

    // One clock: set out_ready, observe handshakes mid-cycle, advance past the edge
    task automatic tick();
        res_t e;
        if (holdoff > 0) begin
            drv_ready = 1'b0;
            holdoff--;
        end else if (rand_ready) begin
            drv_ready = ($urandom_range(0, 3) != 0);
        end else begin
            drv_ready = 1'b1;
        end
        #2;
        obs_acc = 0;
        obs_out = 0;
        if (rst) begin
            exp32.delete(); exp16.delete();
            acc32 = 0; acc16 = 0; ovf32 = 0; ovf16 = 0;
            prev_stall = 0;
        end else begin
            check("in_ready32", bus32.in_ready, !(bus32.out_valid && !drv_ready));
            check("in_ready16", bus16.in_ready, !(bus16.out_valid && !drv_ready));
            if (prev_stall) begin
                check("hold_valid", bus32.out_valid, 1);
                check("hold_x", bus32.out_x, prev_x32);
            end
            if (bus32.out_valid && !drv_ready) n_stall++;
            if (drv_valid && bus32.in_ready) begin
                obs_acc = 1;
                model_accept();
            end
            if (bus32.out_valid && drv_ready) begin
                obs_out = 1;
                n_res++;
                last_x32 = bus32.out_x;
                last_o32 = bus32.out_ovf;
                if (exp32.size() == 0) begin
                    check("out32_unexpected", bus32.out_valid, 0);
                end else begin
                    e = exp32.pop_front();
                    check("out_x32", bus32.out_x, e.x);
                    check("out_ovf32", bus32.out_ovf, e.ovf);
                end
            end
            if (bus16.out_valid && drv_ready) begin
                last_x16 = bus16.out_x;
                last_o16 = bus16.out_ovf;
                if (exp16.size() == 0) begin
                    check("out16_unexpected", bus16.out_valid, 0);
                end else begin
                    e = exp16.pop_front();
                    check("out_x16", bus16.out_x, e.x);
                    check("out_ovf16", bus16.out_ovf, e.ovf);
                end
            end
            prev_stall = bus32.out_valid && !drv_ready;
            prev_x32   = bus32.out_x;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(logic [NL*WA-1:0] a, logic [NL*WB-1:0] b, logic uns, logic last);
        int guard = 0;
        drv_valid = 1'b1; drv_a = a; drv_b = b; drv_uns = uns; drv_last = last;
        do begin
            tick();
            guard++;
        end while (!obs_acc && guard < 50);
        if (!obs_acc) check("beat_accept_timeout", obs_acc, 1);
        drv_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        drv_valid = 1'b0;
        do begin
            tick();
            n++;
        end while (!obs_out && n < 20);
    endtask

    task automatic drain();
        int g = 0;
        drv_valid = 1'b0;
        while ((exp32.size() != 0 || exp16.size() != 0) && g < 40) begin
            tick();
            g++;
        end
        check("drain32", exp32.size(), 0);
        check("drain16", exp16.size(), 0);
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        drv_valid = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    function automatic logic [NL*WA-1:0] pack_a(int v0, int v1, int v2, int v3);
        return {WA'(v3), WA'(v2), WA'(v1), WA'(v0)};
    endfunction

    function automatic logic [NL*WB-1:0] pack_b(int v0, int v1, int v2, int v3);
        return {WB'(v3), WB'(v2), WB'(v1), WB'(v0)};
    endfunction

    initial begin
        int          n, n0, s0;
        logic [31:0] r;
        rst = 1'b1;
        drv_valid = 0; drv_uns = 0; drv_last = 0; drv_ready = 1;
        drv_a = '0; drv_b = '0;
        acc32 = 0; acc16 = 0; ovf32 = 0; ovf16 = 0; prev_stall = 0;

        // Reset state
        do_reset(2);
        check("rst_out_valid", bus32.out_valid, 0);
        check("rst_out_x", bus32.out_x, 0);
        check("rst_out_ovf", bus32.out_ovf, 0);
        check("rst_in_ready", bus32.in_ready, 1);
        check("rst_out_valid16", bus16.out_valid, 0);

        // Signed single-beat dot, latency t+3
        send_beat(pack_a(1, 2, 3, 4), pack_b(5, -6, 7, -8), 1'b0, 1'b1);
        wait_result(n);
        check("t1_latency", n, 3);
        check("t1_x32", last_x32, -18);
        check("t1_ovf32", last_o32, 0);
        check("t1_x16", last_x16, -18);

        // Mode bit: unsigned vs signed of all-ones operands
        send_beat(pack_a(255, 0, 0, 0), pack_b(31, 0, 0, 0), 1'b1, 1'b1);
        wait_result(n);
        check("t2_uns_x32", last_x32, 7905);
        send_beat(pack_a(255, 0, 0, 0), pack_b(31, 0, 0, 0), 1'b0, 1'b1);
        wait_result(n);
        check("t2_sgn_x32", last_x32, 1);

        // Three back-to-back beats accumulate into one result
        n0 = n_res;
        send_beat(pack_a(2, 2, 2, 2), pack_b(3, 3, 3, 3), 1'b0, 1'b0);
        send_beat(pack_a(2, 2, 2, 2), pack_b(3, 3, 3, 3), 1'b0, 1'b0);
        send_beat(pack_a(2, 2, 2, 2), pack_b(3, 3, 3, 3), 1'b0, 1'b1);
        check("t3_no_early_out", n_res, n0);
        wait_result(n);
        check("t3_one_result", n_res, n0 + 1);
        check("t3_x32", last_x32, 72);

        // Eight streamed single-beat dots with a 5-cycle downstream stall
        n0 = n_res;
        s0 = n_stall;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) holdoff = 5;
            r = $urandom;
            send_beat($urandom, r[NL*WB-1:0], 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        check("t4_results", n_res, n0 + 8);
        check("t4_stall_cycles", n_stall, s0 + 5);

        // Overflow on the 16-bit instance, then a clean single beat
        for (int i = 0; i < 4; i++) begin
            send_beat(pack_a(-128, -128, -128, -128), pack_b(-16, -16, -16, -16), 1'b0, 1'(i == 3));
        end
        wait_result(n);
        check("t5_x16", last_x16, -32768);
        check("t5_ovf16", last_o16, 1);
        check("t5_x32", last_x32, 32768);
        check("t5_ovf32", last_o32, 0);
        send_beat(pack_a(1, 0, 0, 0), pack_b(1, 0, 0, 0), 1'b0, 1'b1);
        wait_result(n);
        check("t5_next_ovf16", last_o16, 0);
        check("t5_next_x16", last_x16, 1);

        // Reset mid-accumulation discards the partial sum and in-flight beats
        send_beat(pack_a(2, 2, 2, 2), pack_b(3, 3, 3, 3), 1'b0, 1'b0);
        send_beat(pack_a(2, 2, 2, 2), pack_b(3, 3, 3, 3), 1'b0, 1'b0);
        check("t6_pre_rst_valid", bus32.out_valid, 0);
        do_reset(1);
        check("t6_rst_valid", bus32.out_valid, 0);
        check("t6_rst_x", bus32.out_x, 0);
        send_beat(pack_a(2, 2, 2, 2), pack_b(3, 3, 3, 3), 1'b0, 1'b1);
        wait_result(n);
        check("t6_latency", n, 3);
        check("t6_x32", last_x32, 24);
        check("t6_x16", last_x16, 24);

        // Random beats, bubbles and downstream back-pressure
        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                drv_valid = 1'b0;
                tick();
            end else begin
                r = $urandom;
                send_beat($urandom, r[NL*WB-1:0], 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0));
            end
        end
        r = $urandom;
        send_beat($urandom, r[NL*WB-1:0], 1'b0, 1'b1);
        rand_ready = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
